// File: rtl/alu_md_unit_pkg.sv
// ============================================================================
// alu_defs : shared encodings for alu_md_unit (ctrl, func, alu_op, FSM state)
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_defs;

   localparam logic [2:0] CTRL_AND  = 3'b000;
   localparam logic [2:0] CTRL_OR   = 3'b001;
   localparam logic [2:0] CTRL_XOR  = 3'b010;
   localparam logic [2:0] CTRL_SLT  = 3'b011;
   localparam logic [2:0] CTRL_ADD  = 3'b100;
   localparam logic [2:0] CTRL_ADDU = 3'b101;
   localparam logic [2:0] CTRL_SUB  = 3'b110;
   localparam logic [2:0] CTRL_SUBU = 3'b111;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } md_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_md_unit_if.sv
// ============================================================================
// alu_md_if : EX-stage instruction/result bundle for alu_md_unit
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface alu_md_if #(parameter int WIDTH = 32);
   logic             valid;
   logic [1:0]       alu_op;
   logic [5:0]       func;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             illegal;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid, alu_op, func, a, b,
      input  result, zero, overflow, illegal, busy, done, hi, lo
   );

   modport slave (
      input  valid, alu_op, func, a, b,
      output result, zero, overflow, illegal, busy, done, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/alu_md_unit_md_iter.sv
// ============================================================================
// md_iter : one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             last,
   output logic [WIDTH-1:0] acc_hi,
   output logic [WIDTH-1:0] acc_lo
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_hi, r_lo, r_opb;
   logic             r_div;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   w_madd, w_dsh, w_dsub;

   // Multiply: {hi,lo} starts as {0,multiplier}; divide: {rem,quo} starts as {0,dividend}.
   always_comb begin
      w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
      w_dsh  = {r_hi, r_lo[WIDTH-1]};
      w_dsub = w_dsh - {1'b0, r_opb};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_opb <= '0;
         r_div <= 1'b0;
         r_cnt <= '0;
      end else if (start) begin
         r_hi  <= '0;
         r_lo  <= op_a;
         r_opb <= op_b;
         r_div <= is_div;
         r_cnt <= '0;
      end else if (step) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_div) begin
            r_hi <= w_dsub[WIDTH] ? w_dsh[WIDTH-1:0] : w_dsub[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_dsub[WIDTH]};
         end else begin
            r_hi <= w_madd[WIDTH:1];
            r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
         end
      end
   end

   assign last   = step && (r_cnt == CW'(WIDTH - 1));
   assign acc_hi = r_hi;
   assign acc_lo = r_lo;
endmodule

`default_nettype wire

// File: rtl/alu_md_unit.sv
// ============================================================================
// alu_md_unit : EX-stage ALU decode/execute plus iterative mul/div with HI/LO
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_md_unit
   import alu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     rst,
   alu_md_if.slave bus
);
   logic [2:0]       w_ctrl;
   logic             w_nor, w_mfhi, w_mflo, w_md, w_md_signed, w_md_div, w_illegal;
   logic [WIDTH-1:0] w_sum, w_diff, w_res;
   logic             w_ovf, w_ovf_add, w_ovf_sub, w_slt, w_accept, w_last;
   logic             w_neg_a, w_neg_b;
   logic [WIDTH-1:0] w_mag_a, w_mag_b, w_it_hi, w_it_lo;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;

   md_state_t        r_state;
   logic             r_busy, r_done, r_is_div, r_neg_q, r_neg_r, r_div0;
   logic [WIDTH-1:0] r_hi, r_lo, r_a_raw;

   always_comb begin
      w_ctrl      = CTRL_ADD;
      w_nor       = 1'b0;
      w_mfhi      = 1'b0;
      w_mflo      = 1'b0;
      w_md        = 1'b0;
      w_md_signed = 1'b0;
      w_md_div    = 1'b0;
      w_illegal   = 1'b0;
      if (bus.alu_op == ALUOP_ADD) begin
         w_ctrl = CTRL_ADD;
      end else if (bus.alu_op == ALUOP_SUB) begin
         w_ctrl = CTRL_SUB;
      end else begin
         case (bus.func)
            FN_ADD:   w_ctrl = CTRL_ADD;
            FN_ADDU:  w_ctrl = CTRL_ADDU;
            FN_SUB:   w_ctrl = CTRL_SUB;
            FN_SUBU:  w_ctrl = CTRL_SUBU;
            FN_AND:   w_ctrl = CTRL_AND;
            FN_OR:    w_ctrl = CTRL_OR;
            FN_XOR:   w_ctrl = CTRL_XOR;
            FN_SLT:   w_ctrl = CTRL_SLT;
            FN_NOR:   w_nor  = 1'b1;
            FN_MFHI:  w_mfhi = 1'b1;
            FN_MFLO:  w_mflo = 1'b1;
            FN_MULT:  begin w_md = 1'b1; w_md_signed = 1'b1; end
            FN_MULTU: w_md = 1'b1;
            FN_DIV:   begin w_md = 1'b1; w_md_signed = 1'b1; w_md_div = 1'b1; end
            FN_DIVU:  begin w_md = 1'b1; w_md_div = 1'b1; end
            default:  w_illegal = 1'b1;
         endcase
      end
   end

   assign w_sum     = bus.a + bus.b;
   assign w_diff    = bus.a - bus.b;
   assign w_ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
   assign w_ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
   assign w_slt     = $signed(bus.a) < $signed(bus.b);

   // Mul/div funcs read as zero; their results only appear through MFHI/MFLO.
   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      if (w_illegal || w_md) begin
         w_res = '0;
      end else if (w_nor) begin
         w_res = ~(bus.a | bus.b);
      end else if (w_mfhi) begin
         w_res = r_hi;
      end else if (w_mflo) begin
         w_res = r_lo;
      end else begin
         case (w_ctrl)
            CTRL_AND:  w_res = bus.a & bus.b;
            CTRL_OR:   w_res = bus.a | bus.b;
            CTRL_XOR:  w_res = bus.a ^ bus.b;
            CTRL_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            CTRL_ADD:  begin w_res = w_sum;  w_ovf = w_ovf_add; end
            CTRL_ADDU: w_res = w_sum;
            CTRL_SUB:  begin w_res = w_diff; w_ovf = w_ovf_sub; end
            default:   w_res = w_diff;
         endcase
      end
   end

   assign w_neg_a  = w_md_signed && bus.a[WIDTH-1];
   assign w_neg_b  = w_md_signed && bus.b[WIDTH-1];
   assign w_mag_a  = w_neg_a ? -bus.a : bus.a;
   assign w_mag_b  = w_neg_b ? -bus.b : bus.b;
   assign w_accept = bus.valid && !r_busy && w_md && (r_state == ST_IDLE);

   md_iter #(.WIDTH(WIDTH)) u_md_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (w_accept),
      .step   (r_state == ST_RUN),
      .is_div (w_md_div),
      .op_a   (w_mag_a),
      .op_b   (w_mag_b),
      .last   (w_last),
      .acc_hi (w_it_hi),
      .acc_lo (w_it_lo)
   );

   assign w_prod     = {w_it_hi, w_it_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_a_raw  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_RUN;
                  r_busy   <= 1'b1;
                  r_is_div <= w_md_div;
                  r_neg_q  <= w_neg_a ^ w_neg_b;
                  r_neg_r  <= w_neg_a;
                  r_div0   <= (bus.b == '0);
                  r_a_raw  <= bus.a;
               end
            end
            ST_RUN: begin
               if (w_last) r_state <= ST_FIN;
            end
            ST_FIN: begin
               // Remainder takes the dividend's sign; quotient truncates toward zero.
               if (!r_is_div) begin
                  {r_hi, r_lo} <= w_prod_fix;
               end else if (r_div0) begin
                  r_hi <= r_a_raw;
                  r_lo <= '1;
               end else begin
                  r_hi <= r_neg_r ? -w_it_hi : w_it_hi;
                  r_lo <= r_neg_q ? -w_it_lo : w_it_lo;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.result   = w_res;
   assign bus.zero     = (w_res == '0);
   assign bus.overflow = w_ovf;
   assign bus.illegal  = w_illegal;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
endmodule

`default_nettype wire

// File: tb/tb_alu_md_unit.sv
// ============================================================================
// tb_alu_md_unit : directed self-checking bench for alu_md_unit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alu_md_unit;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   alu_md_if #(.WIDTH(WIDTH)) bus ();

   alu_md_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      bus.alu_op = op;
      bus.func   = fn;
      bus.a      = a;
      bus.b      = b;
      #1;
   endtask

   // Issue a mul/div, expect done WIDTH+1 edges after accept, then MFHI in the done cycle.
   task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      @(negedge clk);
      bus.valid = 1'b1;
      drive(2'b10, fn, a, b);
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      n = 0;
      while (!bus.done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd33);
      check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
      drive(2'b10, 6'b010000, 32'd0, 32'd0);
      check({tag, " mfhi_done_cycle"}, 64'(bus.result), 64'(exp_hi));
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int n;
      int dones;
      bus.valid = 1'b0;
      drive(2'b00, 6'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst done", 64'(bus.done), 64'd0);
      check("rst hi", 64'(bus.hi), 64'd0);
      check("rst lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      drive(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1);
      check("add result", 64'(bus.result), 64'h8000_0000);
      check("add ovf", 64'(bus.overflow), 64'd1);
      drive(2'b10, 6'b100001, 32'h7FFF_FFFF, 32'd1);
      check("addu ovf", 64'(bus.overflow), 64'd0);
      drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
      check("slt", 64'(bus.result), 64'd1);
      drive(2'b10, 6'b111111, 32'h1234, 32'h5678);
      check("illegal flag", 64'(bus.illegal), 64'd1);
      check("illegal result", 64'(bus.result), 64'd0);
      drive(2'b01, 6'b111111, 32'h8000_0000, 32'd1);
      check("aluop sub result", 64'(bus.result), 64'h7FFF_FFFF);
      check("aluop sub ovf", 64'(bus.overflow), 64'd1);
      check("aluop sub illegal", 64'(bus.illegal), 64'd0);
      drive(2'b10, 6'b100111, 32'hF0F0_0000, 32'h0000_00FF);
      check("nor", 64'(bus.result), 64'h0F0F_FF00);
      drive(2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0);
      check("and", 64'(bus.result), 64'h0F00_0F00);
      drive(2'b00, 6'd0, 32'd5, 32'hFFFF_FFFB);
      check("add zero", 64'(bus.zero), 64'd1);
      drive(2'b10, 6'b100010, 32'd5, 32'd7);
      check("sub result", 64'(bus.result), 64'hFFFF_FFFE);

      run_md("mult", 6'b011000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_md("multu", 6'b011001, 32'hFFFF_FFFD, 32'd7, 32'd6, 32'hFFFF_FFEB);
      drive(2'b10, 6'b010000, 32'd0, 32'd0);
      check("mfhi", 64'(bus.result), 64'd6);
      drive(2'b10, 6'b010010, 32'd0, 32'd0);
      check("mflo", 64'(bus.result), 64'hFFFF_FFEB);
      run_md("div", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
      run_md("div0", 6'b011010, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

      // MULT with valid held; a DIV presented mid-flight must be ignored.
      @(negedge clk);
      bus.valid = 1'b1;
      drive(2'b10, 6'b011000, 32'd3, 32'd4);
      repeat (5) @(negedge clk);
      drive(2'b10, 6'b011010, 32'd100, 32'd7);
      check("md busy result", 64'(bus.result), 64'd0);
      n = 0;
      while (!bus.done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      bus.valid = 1'b0;
      check("ignore hi", 64'(bus.hi), 64'd0);
      check("ignore lo", 64'(bus.lo), 64'd12);
      repeat (3) @(posedge clk);
      #1;
      check("ignore busy", 64'(bus.busy), 64'd0);

      // Reset mid-MULT discards the op.
      @(negedge clk);
      bus.valid = 1'b1;
      drive(2'b10, 6'b011000, 32'd9, 32'd9);
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst busy", 64'(bus.busy), 64'd0);
      check("midrst hi", 64'(bus.hi), 64'd0);
      check("midrst lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("midrst no done", 64'(dones), 64'd0);
      check("midrst lo hold", 64'(bus.lo), 64'd0);
      run_md("divu_after_rst", 6'b011011, 32'd9, 32'd2, 32'd1, 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

`default_nettype wire
